sm_fetch_queue: RTL and testbench
=================================

Name: sm_fetch_queue

Overview:
- Instruction prefetch stage between the dual-read instruction ROM and the decode stage.
- Owns the fetch PC and drives the ROM word address each cycle.
- Captures up to two consecutive instruction words per cycle (ROM ports rd[0] = word a, rd[1] = word a+1) into a small queue.
- Presents one instruction per cycle to decode over a valid/ready handshake; flushes on control-flow redirect.

Parameters:
- DEPTH, 4, queue entries (power of two, >= 2); each entry holds {pc[31:0], instr[31:0]}.
- RESET_PC, 32'h0000_0000, byte address of the first fetch after reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- imAddr  out  32  ROM word address = fetch_pc >> 2.
- imData0  in  32  ROM word at imAddr (combinational ROM).
- imData1  in  32  ROM word at imAddr+1.
- redirect  in  1  flush queue and restart fetch at redirect_pc.
- redirect_pc  in  32  byte target; bits [1:0] ignored (forced to 0).
- instr_valid  out  1  head entry valid.
- instr  out  32  head instruction.
- instr_pc  out  32  byte PC of head instruction.
- instr_ready  in  1  decode accepts head this cycle.

Behaviour:
- Reset: one clock, synchronous and active-low. rst_n sampled low at a rising edge sets fetch_pc = RESET_PC & ~3, count = 0, rd/wr pointers = 0. Outputs while/after reset: instr_valid = 0; instr and instr_pc are don't-care (implement as 0); imAddr = RESET_PC >> 2.
- State: fetch_pc[31:0]; head/tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH; count of $clog2(DEPTH)+1 bits, range 0..DEPTH.
- free = DEPTH - count, using the registered count. No same-cycle credit from a dequeue.
- Enqueue width n:
  - free >= 2: n = 2.
  - free == 1: n = 1.
  - free == 0: n = 0.
- Enqueue action:
  - imData0 is written with pc = fetch_pc.
  - imData1 is written with pc = fetch_pc + 4, only when n = 2.
  - fetch_pc += 4*n; 32-bit wrap-around modulo 2^32.
- Dequeue: deq = instr_valid & instr_ready; head advances by 1.
- Count update: count_next = count + n - deq.
- Outputs: instr_valid = (count != 0); instr and instr_pc are driven from the head entry.
- Latency: an instruction enqueued at edge k is visible at the output in the cycle after edge k. First valid instruction appears 1 cycle after rst_n is sampled high.
- Throughput: steady state is 1 instruction/cycle with instr_ready held at 1; the queue never underflows.
- Redirect (priority over enqueue, below reset):
  - count = 0, pointers reset, no enqueue that cycle.
  - fetch_pc = redirect_pc & ~3.
  - A handshake completing in the redirect cycle still counts as accepted by decode.
  - instr_valid = 0 in the next cycle; the target instruction is valid one cycle after that.
- Full queue: imAddr is held constant and nothing is written. imData is ignored.
- Reset mid-operation discards all queued entries; no partial state survives.
- Out-of-range imAddr beyond ROM size is not detected here; the ROM index behaviour governs.

Decomposition:
- Shared header sm_fetch_defs: DEPTH default, instruction word width, PC width, alignment mask 32'hFFFF_FFFC.
- Sub-module sm_fetch_fifo: 2-write/1-read FIFO with write count 0..2, read enable, synchronous flush, count output.
- sm_fetch_queue itself: fetch_pc register, enqueue-width logic, redirect handling.

Test Plan:
- ROM word i = 32'hA000_0000 + i; reset low 2 cycles then high, instr_ready = 1 -> cycle 1 after release: instr = A0000000, pc 0x0. Then one instruction per cycle with pc 0x4, 0x8, …; instr_valid never drops.
- instr_ready = 0 after reset -> count reaches 4 after 2 cycles; imAddr holds 4 (fetch_pc 0x10); instr stays A0000000/0x0.
- From full (DEPTH = 4), pulse instr_ready for 1 cycle -> head becomes A0000001/0x4, count 3. Next cycle one word enqueued (A0000004); imAddr = 5; count back to 4.
- count = 2, instr_ready = 1 -> same cycle 2 enqueued + 1 dequeued; count = 3 next cycle.
- redirect = 1, redirect_pc = 0x22 while full -> next cycle instr_valid = 0, imAddr = 8. Following cycle instr = A0000008, instr_pc = 0x20.
- Queue full, rst_n low for one cycle -> next cycle instr_valid = 0, imAddr = 0, count = 0. Fetch resumes at pc 0x0 after release.

Source files
------------

// File: rtl/sm_fetch_defs.sv
`default_nettype none
// ============================================================================
// Module   : sm_fetch_defs (package)
// Purpose  : Shared widths, defaults and queue entry type for the fetch stage.
// Revision : 1.0
// ============================================================================
package sm_fetch_defs;

    localparam int C_DEPTH   = 4;
    localparam int C_INSTR_W = 32;
    localparam int C_PC_W    = 32;

    localparam logic [C_PC_W-1:0] C_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [C_PC_W-1:0]    pc;
        logic [C_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage : sm_fetch_defs
`default_nettype wire

// File: rtl/sm_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sm_fetch_fifo
// Purpose  : 2-write / 1-read circular queue with synchronous flush.
// Revision : 1.0
// ============================================================================
module sm_fetch_fifo
    import sm_fetch_defs::*;
#(
    parameter int DEPTH = C_DEPTH,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic [1:0]    wr_cnt,
    input  fetch_entry_t  wr_data0,
    input  fetch_entry_t  wr_data1,
    input  logic          rd_en,
    output fetch_entry_t  rd_data,
    output logic [CW-1:0] count
);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [PW-1:0] w_wr_ptr1;

    // Second write slot wraps independently of the first.
    assign w_wr_ptr1 = r_wr_ptr + PW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(wr_cnt);
            r_rd_ptr <= r_rd_ptr + PW'(rd_en);
            r_count  <= r_count + CW'(wr_cnt) - CW'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !flush) begin
            if (wr_cnt != 2'd0) r_mem[r_wr_ptr]  <= wr_data0;
            if (wr_cnt == 2'd2) r_mem[w_wr_ptr1] <= wr_data1;
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign count   = r_count;

endmodule : sm_fetch_fifo
`default_nettype wire

// File: rtl/sm_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : sm_fetch_queue
// Purpose  : Prefetch stage: owns fetch PC, buffers dual ROM words for decode.
// Revision : 1.0
// ============================================================================
module sm_fetch_queue
    import sm_fetch_defs::*;
#(
    parameter int          DEPTH    = C_DEPTH,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imAddr,
    input  logic [31:0] imData0,
    input  logic [31:0] imData1,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [C_PC_W-1:0] r_fetch_pc;
    logic [CW-1:0]     w_count;
    logic [CW-1:0]     w_free;
    logic [1:0]        w_wr_cnt;
    logic              w_deq;
    fetch_entry_t      w_wr0;
    fetch_entry_t      w_wr1;
    fetch_entry_t      w_head;

    // Free space uses the registered count only; a dequeue this cycle
    // does not open a slot until the next cycle.
    assign w_free = CW'(DEPTH) - w_count;

    always_comb begin
        w_wr_cnt = 2'd0;
        if (!redirect) begin
            if (w_free >= CW'(2))      w_wr_cnt = 2'd2;
            else if (w_free == CW'(1)) w_wr_cnt = 2'd1;
        end
    end

    assign w_deq = instr_valid & instr_ready;
    assign w_wr0 = '{pc: r_fetch_pc,         instr: imData0};
    assign w_wr1 = '{pc: r_fetch_pc + 32'd4, instr: imData1};

    always_ff @(posedge clk) begin
        if (!rst_n)        r_fetch_pc <= RESET_PC & C_ALIGN_MASK;
        else if (redirect) r_fetch_pc <= redirect_pc & C_ALIGN_MASK;
        else               r_fetch_pc <= r_fetch_pc + {28'd0, w_wr_cnt, 2'b00};
    end

    sm_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect),
        .wr_cnt   (w_wr_cnt),
        .wr_data0 (w_wr0),
        .wr_data1 (w_wr1),
        .rd_en    (w_deq),
        .rd_data  (w_head),
        .count    (w_count)
    );

    assign imAddr      = {2'b00, r_fetch_pc[31:2]};
    assign instr_valid = (w_count != '0);
    assign instr       = instr_valid ? w_head.instr : '0;
    assign instr_pc    = instr_valid ? w_head.pc    : '0;

endmodule : sm_fetch_queue
`default_nettype wire

// File: tb/tb_sm_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_sm_fetch_queue
// Purpose  : Directed bench with an expected-instruction scoreboard.
// Revision : 1.0
// ============================================================================
module tb_sm_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imAddr;
    logic [31:0] imData0;
    logic [31:0] imData1;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] w);
        return 32'hA000_0000 + w;
    endfunction

    assign imData0 = rom(imAddr);
    assign imData1 = rom(imAddr + 32'd1);

    sm_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imAddr      (imAddr),
        .imData0     (imData0),
        .imData1     (imData1),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_pc;
    int          m_free;
    int          checks = 0;
    int          errors = 0;

    // Reference model: expected queue contents pushed as words are fetched.
    always @(posedge clk) begin
        if (!rst_n) begin
            sb.delete();
            m_pc = RESET_PC & 32'hFFFF_FFFC;
        end else if (redirect) begin
            sb.delete();
            m_pc = redirect_pc & 32'hFFFF_FFFC;
        end else begin
            m_free = DEPTH - sb.size();
            if (sb.size() != 0 && instr_ready) void'(sb.pop_front());
            if (m_free >= 1) sb.push_back('{m_pc, rom(m_pc >> 2)});
            if (m_free >= 2) sb.push_back('{m_pc + 32'd4, rom((m_pc >> 2) + 32'd1)});
            m_pc = m_pc + ((m_free >= 2) ? 32'd8 : (m_free == 1) ? 32'd4 : 32'd0);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and compare every output against the scoreboard.
    task automatic cycle();
        @(negedge clk);
        check("valid", {31'd0, instr_valid}, {31'd0, sb.size() != 0});
        check("imAddr", imAddr, m_pc >> 2);
        check("count", 32'(dut.w_count), 32'(sb.size()));
        if (sb.size() != 0) begin
            check("instr", instr, sb[0].ins);
            check("instr_pc", instr_pc, sb[0].pc);
        end else begin
            check("instr_idle", instr, 32'd0);
            check("pc_idle", instr_pc, 32'd0);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        instr_ready = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'd0;

        // Reset then streaming at one instruction per cycle
        cycle();
        cycle();
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_imAddr", imAddr, 32'd0);
        rst_n = 1'b1;
        cycle();
        check("first_instr", instr, 32'hA000_0000);
        check("first_pc", instr_pc, 32'h0);
        check("first_count", 32'(dut.w_count), 32'd2);
        for (int k = 1; k <= 6; k++) begin
            cycle();
            check("stream_valid", {31'd0, instr_valid}, 32'd1);
            check("stream_instr", instr, 32'hA000_0000 + 32'(k));
            check("stream_pc", instr_pc, 32'(4 * k));
            if (k == 1) check("dual_enq_count", 32'(dut.w_count), 32'd3);
        end

        // Fill with decode stalled
        rst_n       = 1'b0;
        instr_ready = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
        cycle();
        check("full_count", 32'(dut.w_count), 32'd4);
        check("full_imAddr", imAddr, 32'd4);
        check("full_instr", instr, 32'hA000_0000);
        check("full_pc", instr_pc, 32'h0);
        cycle();
        check("full_hold_imAddr", imAddr, 32'd4);

        // Single-cycle accept from full
        instr_ready = 1'b1;
        cycle();
        check("pop_instr", instr, 32'hA000_0001);
        check("pop_pc", instr_pc, 32'h4);
        check("pop_count", 32'(dut.w_count), 32'd3);
        instr_ready = 1'b0;
        cycle();
        check("refill_imAddr", imAddr, 32'd5);
        check("refill_count", 32'(dut.w_count), 32'd4);

        // Redirect while full, with a handshake in the same cycle
        redirect    = 1'b1;
        redirect_pc = 32'h22;
        instr_ready = 1'b1;
        cycle();
        check("redir_valid", {31'd0, instr_valid}, 32'd0);
        check("redir_imAddr", imAddr, 32'd8);
        redirect = 1'b0;
        cycle();
        check("redir_instr", instr, 32'hA000_0008);
        check("redir_pc", instr_pc, 32'h20);

        // Reset while full
        instr_ready = 1'b0;
        cycle();
        cycle();
        check("pre_rst_count", 32'(dut.w_count), 32'd4);
        rst_n = 1'b0;
        cycle();
        check("midrst_valid", {31'd0, instr_valid}, 32'd0);
        check("midrst_imAddr", imAddr, 32'd0);
        check("midrst_count", 32'(dut.w_count), 32'd0);
        rst_n       = 1'b1;
        instr_ready = 1'b1;
        cycle();
        check("resume_instr", instr, 32'hA000_0000);
        check("resume_pc", instr_pc, 32'h0);

        // PC wrap-around at the top of the address space
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF9;
        cycle();
        redirect = 1'b0;
        cycle();
        check("wrap_pc0", instr_pc, 32'hFFFF_FFF8);
        check("wrap_instr0", instr, 32'hDFFF_FFFE);
        cycle();
        check("wrap_pc1", instr_pc, 32'hFFFF_FFFC);
        cycle();
        check("wrap_pc2", instr_pc, 32'h0);
        check("wrap_instr2", instr, 32'hA000_0000);

        // Mixed stalls and occasional redirects against the scoreboard
        for (int k = 0; k < 60; k++) begin
            instr_ready = 1'($urandom_range(0, 1));
            redirect    = ($urandom_range(0, 9) == 0);
            redirect_pc = 32'($urandom_range(0, 255));
            cycle();
        end
        redirect = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sm_fetch_queue
`default_nettype wire
